down_timer: RTL and testbench

- Loadable, cascadable down-counter/timer. Complements the existing modulo up-counter: it counts down from a programmed value instead of up to a fixed modulus.
- Counts one step per `en` tick. `en` is typically the carry-out of an upstream prescaler counter.
- Emits a borrow-out `bo` on expiry, so stages can be chained.
- Supports one-shot and periodic (auto-reload) modes. Status is `busy`, a registered `done` pulse and a sticky `expired` flag.

---
 rtl/down_timer.sv | 122 ++++++++++++
 tb/tb_down_timer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
// Module   : down_timer
// Purpose  : Loadable, cascadable down-counter/timer. Counts down one step
//            per en tick from a programmed start value. Supports one-shot
//            and periodic (auto-reload) modes. Signals expiry with a
//            combinational borrow-out so that stages can be chained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : system clock, rising-edge active
//   rst        : asynchronous active-high reset
//   en_i       : count tick (decrement only when 1)
//   start_i    : pulse; latch load_val_i/periodic_i and begin counting
//   stop_i     : pulse; abort the run, count holds
//   clr_i      : clear the sticky expired flag
//   periodic_i : mode, sampled on start (1 = auto-reload, 0 = one-shot)
//   load_val_i : start value; period is load_val_i+1 en ticks
//   cnt_o      : current count
//   busy_o     : 1 while running
//   bo_o       : combinational borrow-out = en & RUN & (cnt==0)
//   done_o     : registered copy of bo_o
//   expired_o  : sticky expiry flag
// ============================================================================
module down_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         clr_i,
  input  logic         periodic_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         busy_o,
  output logic         bo_o,
  output logic         done_o,
  output logic         expired_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         done_q;
  logic         expired_q, expired_d;
  logic         bo_w;

  // Borrow depends only on en and registered state, which is what lets a
  // downstream stage use it as its en without adding a cycle of latency.
  assign bo_w = en_i && (state_q == S_RUN) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = expired_q;

    // clr is applied first so that a same-cycle expiry overrides it.
    if (clr_i) begin
      expired_d = 1'b0;
    end

    if (start_i) begin
      cnt_d     = load_val_i;
      reload_d  = load_val_i;
      mode_d    = periodic_i;
      state_d   = S_RUN;
      expired_d = 1'b0;
    end else if (stop_i) begin
      state_d = S_IDLE;
    end else if ((state_q == S_RUN) && en_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - C_ONE;
      end else begin
        expired_d = 1'b1;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          // One-shot terminal tick: count rests at zero, never wraps.
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      done_q    <= bo_w;
      expired_q <= expired_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign busy_o    = (state_q == S_RUN);
  assign bo_o      = bo_w;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_timer
// Purpose  : Self-checking bench for down_timer (W=8). A second instance is
//            chained from the first instance's borrow-out for the cascade
//            scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_timer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en, start, stop, clr, periodic;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         busy, bo, done, expired;

  logic         start_b, periodic_b;
  logic [W-1:0] load_b;
  logic [W-1:0] cnt_b;
  logic         busy_b, bo_b, done_b, expired_b;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         bo;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];

  down_timer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .start_i    (start),
    .stop_i     (stop),
    .clr_i      (clr),
    .periodic_i (periodic),
    .load_val_i (load_val),
    .cnt_o      (cnt),
    .busy_o     (busy),
    .bo_o       (bo),
    .done_o     (done),
    .expired_o  (expired)
  );

  down_timer #(.W(W)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en_i       (bo),
    .start_i    (start_b),
    .stop_i     (1'b0),
    .clr_i      (1'b0),
    .periodic_i (periodic_b),
    .load_val_i (load_b),
    .cnt_o      (cnt_b),
    .busy_o     (busy_b),
    .bo_o       (bo_b),
    .done_o     (done_b),
    .expired_o  (expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one clock with the given value and mode.
  task automatic do_start(input logic [W-1:0] v, input logic p);
    start    = 1'b1;
    load_val = v;
    periodic = p;
    cyc();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    n_checks++;
    if ({cnt, busy, bo, done, expired} !== {8'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d busy=%b bo=%b done=%b exp=%b, want 0/0/0/0/0",
               cnt, busy, bo, done, expired);
    end
    rst = 1'b0;
    cyc();
    do_start(8'd5, 1'b1);
    en = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_prerun_cnt: got %0d want 2", cnt);
    end
    // Asynchronous: effect must be visible without a clock edge.
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cnt, busy, bo, done, expired} !== {8'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_async: got cnt=%0d busy=%b bo=%b done=%b exp=%b, want 0/0/0/0/0",
               cnt, busy, bo, done, expired);
    end
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if ({cnt, busy, bo} !== {8'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_idle_after: got cnt=%0d busy=%b bo=%b want 0/0/0", cnt, busy, bo);
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    exp_t e;
    en = 1'b1;                       // en in the start cycle must be ignored
    do_start(8'd3, 1'b0);
    exp_q.push_back({8'd3, 1'b0});
    exp_q.push_back({8'd2, 1'b0});
    exp_q.push_back({8'd1, 1'b0});
    exp_q.push_back({8'd0, 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({cnt, bo, busy} !== {e.cnt, e.bo, 1'b1}) begin
        n_fail++;
        $display("FAIL oneshot_seq: got cnt=%0d bo=%b busy=%b want cnt=%0d bo=%b busy=1",
                 cnt, bo, busy, e.cnt, e.bo);
      end
      cyc();
    end
    n_checks++;
    if ({cnt, busy, bo, done, expired} !== {8'd0, 4'b0011}) begin
      n_fail++;
      $display("FAIL oneshot_end: got cnt=%0d busy=%b bo=%b done=%b exp=%b want 0/0/0/1/1",
               cnt, busy, bo, done, expired);
    end
    cyc();
    n_checks++;
    if ({done, expired, cnt} !== {2'b01, 8'd0}) begin
      n_fail++;
      $display("FAIL oneshot_done_pulse: got done=%b exp=%b cnt=%0d want 0/1/0", done, expired, cnt);
    end
    en  = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_checks++;
    if (expired !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_clr: got expired=%b want 0", expired);
    end
  endtask

  task automatic test_periodic_gaps();
    exp_t e;
    int   n_bo;
    n_bo = 0;
    en   = 1'b0;
    do_start(8'd2, 1'b1);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({8'd2, 1'b0});
      exp_q.push_back({8'd1, 1'b0});
      exp_q.push_back({8'd0, 1'b1});
    end
    for (int k = 0; k < 18; k++) begin
      en = (k % 3 == 2);
      if (k == 4) load_val = 8'd7;   // must not affect the running period
      #1;
      if (en) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({cnt, bo, busy} !== {e.cnt, e.bo, 1'b1}) begin
          n_fail++;
          $display("FAIL periodic_tick k=%0d: got cnt=%0d bo=%b busy=%b want cnt=%0d bo=%b busy=1",
                   k, cnt, bo, busy, e.cnt, e.bo);
        end
      end else begin
        n_checks++;
        if ({bo, busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL periodic_gap k=%0d: got bo=%b busy=%b want bo=0 busy=1", k, bo, busy);
        end
      end
      if (bo) n_bo++;
      cyc();
    end
    n_checks++;
    if ({n_bo, cnt} !== {32'd2, 8'd2}) begin
      n_fail++;
      $display("FAIL periodic_total: got bo_count=%0d cnt=%0d want 2/2", n_bo, cnt);
    end
    en   = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_boundaries();
    int hit;
    en = 1'b1;
    do_start(8'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({cnt, bo, busy} !== {8'd0, 2'b11}) begin
        n_fail++;
        $display("FAIL div1 k=%0d: got cnt=%0d bo=%b busy=%b want 0/1/1", k, cnt, bo, busy);
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    // Full-range one-shot: expected borrow on the 256th en tick.
    cyc_q.push_back(256);
    hit = 0;
    do_start(8'd255, 1'b0);
    for (int t = 1; t <= 300; t++) begin
      if (bo) begin
        hit = t;
        break;
      end
      cyc();
    end
    n_checks++;
    if (hit !== cyc_q.pop_front()) begin
      n_fail++;
      $display("FAIL full_range_bo_tick: got %0d want 256 (0 = no bo within 300)", hit);
    end
    cyc();
    n_checks++;
    if ({busy, cnt, expired} !== {1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_range_end: got busy=%b cnt=%0d exp=%b want 0/0/1", busy, cnt, expired);
    end
    en = 1'b0;
  endtask

  task automatic test_simultaneous();
    // start + stop: start wins.
    stop = 1'b1;
    do_start(8'd9, 1'b1);
    stop = 1'b0;
    n_checks++;
    if ({busy, cnt, expired} !== {1'b1, 8'd9, 1'b0}) begin
      n_fail++;
      $display("FAIL start_stop: got busy=%b cnt=%0d exp=%b want 1/9/0", busy, cnt, expired);
    end
    en = 1'b1;
    repeat (5) cyc();
    // stop at cnt=4: idle, value held, no borrow.
    stop = 1'b1;
    #1;
    n_checks++;
    if ({cnt, bo} !== {8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_cycle: got cnt=%0d bo=%b want 4/0", cnt, bo);
    end
    cyc();
    stop = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({busy, cnt, bo, expired} !== {1'b0, 8'd4, 2'b00}) begin
      n_fail++;
      $display("FAIL stop_hold: got busy=%b cnt=%0d bo=%b exp=%b want 0/4/0/0", busy, cnt, bo, expired);
    end
    // clr coincident with bo: set wins.
    en = 1'b0;
    do_start(8'd1, 1'b1);
    en = 1'b1;
    cyc();
    clr = 1'b1;
    #1;
    n_checks++;
    if (bo !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_bo_setup: got bo=%b want 1", bo);
    end
    cyc();
    clr = 1'b0;
    n_checks++;
    if ({expired, cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL clr_bo_set_wins: got exp=%b cnt=%0d want 1/1", expired, cnt);
    end
    // Restart while running at cnt=1.
    do_start(8'd6, 1'b1);
    n_checks++;
    if ({cnt, busy, done, expired} !== {8'd6, 3'b100}) begin
      n_fail++;
      $display("FAIL restart: got cnt=%0d busy=%b done=%b exp=%b want 6/1/0/0", cnt, busy, done, expired);
    end
    cyc();
    n_checks++;
    if (cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL restart_count: got %0d want 5", cnt);
    end
    en   = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_cascade();
    int exp_cyc;
    en         = 1'b0;
    start_b    = 1'b1;
    load_b     = 8'd4;
    periodic_b = 1'b1;
    do_start(8'd3, 1'b1);
    start_b = 1'b0;
    cyc_q.push_back(20);
    cyc_q.push_back(40);
    cyc_q.push_back(60);
    en = 1'b1;
    for (int t = 1; t <= 61; t++) begin
      #1;
      if (bo_b) begin
        exp_cyc = (cyc_q.size() > 0) ? cyc_q.pop_front() : -1;
        n_checks++;
        if ({t, bo} !== {exp_cyc, 1'b1}) begin
          n_fail++;
          $display("FAIL cascade_bo: got B.bo at clk %0d with A.bo=%b want clk %0d with A.bo=1",
                   t, bo, exp_cyc);
        end
      end
      cyc();
    end
    n_checks++;
    if (cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL cascade_missing: %0d expected B borrows not seen, want 0", cyc_q.size());
    end
    en = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    en         = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    clr        = 1'b0;
    periodic   = 1'b0;
    load_val   = '0;
    start_b    = 1'b0;
    periodic_b = 1'b0;
    load_b     = '0;
    test_reset();
    test_oneshot();
    test_periodic_gaps();
    test_boundaries();
    test_simultaneous();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
